// File: rtl/wb_arbiter_pkg.sv
// Shared types for the register-file write-back arbiter: source indices and the queued {rd, data} entry.
package wb_arbiter_pkg;

    localparam int RD_W        = 5;
    localparam int WB_DATA_MAX = 64;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    typedef logic [RD_W-1:0] rd_t;

    // Data is carried at the widest supported width; each instance keeps only its low DATA_W bits.
    typedef struct packed {
        rd_t                    rd;
        logic [WB_DATA_MAX-1:0] data;
    } wb_entry_t;

    function automatic logic is_x0(input rd_t r);
        return (r == '0);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-source write-back queue: power-of-two ring buffer with wrap-around pointers and an occupancy count.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push_i,
    input  wb_entry_t push_entry_i,
    input  logic      pop_i,
    output logic      full_o,
    output logic      empty_o,
    output wb_entry_t head_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [RD_W-1:0]   rd_mem   [FIFO_DEPTH];
    logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
    logic              push_ok;
    logic              pop_ok;
    logic              unused_push_hi;

    assign full_o         = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty_o        = (count_q == '0);
    assign push_ok        = push_i & ~full_o;
    assign pop_ok         = pop_i & ~empty_o;
    assign unused_push_hi = ^push_entry_i.data;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            rd_mem[wr_ptr_q]   <= push_entry_i.rd;
            data_mem[wr_ptr_q] <= push_entry_i.data[DATA_W-1:0];
        end
    end

    always_comb begin
        head_o                   = '0;
        head_o.rd                = rd_mem[rd_ptr_q];
        head_o.data[DATA_W-1:0]  = data_mem[rd_ptr_q];
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: queues ALU and load results, picks one per cycle round-robin,
// and registers it onto the register-file write port.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    input  logic [RD_W-1:0]   alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [RD_W-1:0]   mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    output logic [RD_W-1:0]   rd,
    output logic [DATA_W-1:0] write_data,
    output logic              reg_write
);

    wb_entry_t         alu_entry, mem_entry;
    wb_entry_t         alu_head, mem_head, sel_entry;
    logic              alu_full, alu_empty, mem_full, mem_empty;
    logic              alu_push, mem_push, alu_pop, mem_pop;
    logic              unused_sel_hi;
    src_e              last_q, last_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;

    // Ready is a pure function of occupancy, so a same-cycle pop never opens the queue early.
    assign alu_ready = rst_n & ~alu_full;
    assign mem_ready = rst_n & ~mem_full;
    assign alu_push  = alu_valid & alu_ready;
    assign mem_push  = mem_valid & mem_ready;

    always_comb begin
        alu_entry                   = '0;
        alu_entry.rd                = alu_rd;
        alu_entry.data[DATA_W-1:0]  = alu_data;
        mem_entry                   = '0;
        mem_entry.rd                = mem_rd;
        mem_entry.data[DATA_W-1:0]  = mem_data;
    end

    wb_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_alu_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (alu_push),
        .push_entry_i (alu_entry),
        .pop_i        (alu_pop),
        .full_o       (alu_full),
        .empty_o      (alu_empty),
        .head_o       (alu_head)
    );

    wb_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_mem_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (mem_push),
        .push_entry_i (mem_entry),
        .pop_i        (mem_pop),
        .full_o       (mem_full),
        .empty_o      (mem_empty),
        .head_o       (mem_head)
    );

    // On a tie the source that did not win last time is granted.
    always_comb begin
        alu_pop   = 1'b0;
        mem_pop   = 1'b0;
        last_d    = last_q;
        sel_entry = alu_head;
        if (!alu_empty && (mem_empty || last_q == SRC_MEM)) begin
            alu_pop = 1'b1;
            last_d  = SRC_ALU;
        end else if (!mem_empty) begin
            mem_pop   = 1'b1;
            last_d    = SRC_MEM;
            sel_entry = mem_head;
        end
    end

    assign unused_sel_hi = ^sel_entry.data;

    // x0 writes are drained from the queue but never enable the register file.
    always_comb begin
        rd_d    = rd_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        if (alu_pop || mem_pop) begin
            rd_d    = sel_entry.rd;
            wdata_d = sel_entry.data[DATA_W-1:0];
            we_d    = ~is_x0(sel_entry.rd);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q  <= SRC_MEM;
            rd_q    <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            last_q  <= last_d;
            rd_q    <= rd_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
        end
    end

    assign rd         = rd_q;
    assign write_data = wdata_q;
    assign reg_write  = we_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed vector table, multi-cycle sequences and a queue-level reference model.
module tb_wb_arbiter;

    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic          clk;
    logic          rst_n;
    logic          alu_valid, mem_valid;
    logic [4:0]    alu_rd, mem_rd;
    logic [DW-1:0] alu_data, mem_data;
    logic          alu_ready, mem_ready;
    logic [4:0]    rd;
    logic [DW-1:0] write_data;
    logic          reg_write;

    wb_arbiter #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .alu_ready  (alu_ready),
        .mem_valid  (mem_valid),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .mem_ready  (mem_ready),
        .rd         (rd),
        .write_data (write_data),
        .reg_write  (reg_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]    rd;
        logic [DW-1:0] data;
    } ent_t;

    typedef struct {
        bit            av;
        logic [4:0]    ard;
        logic [DW-1:0] ad;
        bit            mv;
        logic [4:0]    mrd;
        logic [DW-1:0] md;
        bit            we;
        logic [4:0]    rd;
        logic [DW-1:0] wd;
        bit            ar;
        bit            mr;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: one queue per source plus the last granted source.
    ent_t          aq[$];
    ent_t          mq[$];
    ent_t          dlog[$];
    bit            last_mem;
    logic [4:0]    exp_rd;
    logic [DW-1:0] exp_wd;
    bit            exp_we;
    bit            model_chk;
    bit            last_pa, last_pm;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int av, input int ard, input logic [31:0] ad,
                                input int mv, input int mrd, input logic [31:0] md,
                                input int we, input int erd, input logic [31:0] wd,
                                input int ar, input int mr);
        vec_t v;
        v.av = (av != 0); v.ard = 5'(ard); v.ad = ad;
        v.mv = (mv != 0); v.mrd = 5'(mrd); v.md = md;
        v.we = (we != 0); v.rd = 5'(erd);  v.wd = wd;
        v.ar = (ar != 0); v.mr = (mr != 0);
        return v;
    endfunction

    task automatic model_reset();
        aq.delete();
        mq.delete();
        last_mem = 1'b1;
        exp_rd   = '0;
        exp_wd   = '0;
        exp_we   = 1'b0;
        last_pa  = 1'b0;
        last_pm  = 1'b0;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    endtask

    // One clock: model decides from pre-edge state, then DUT outputs are sampled 1 ns after the edge.
    task automatic tick();
        ent_t e, ea, em;
        bit   pa, pm, ga, gm;
        pa = alu_valid && (aq.size() < DEPTH);
        pm = mem_valid && (mq.size() < DEPTH);
        ea.rd = alu_rd; ea.data = alu_data;
        em.rd = mem_rd; em.data = mem_data;
        ga = (aq.size() != 0) && ((mq.size() == 0) || last_mem);
        gm = (mq.size() != 0) && !ga;
        @(posedge clk);
        #1;
        exp_we = 1'b0;
        if (ga) begin
            e = aq.pop_front();
            last_mem = 1'b0;
        end else if (gm) begin
            e = mq.pop_front();
            last_mem = 1'b1;
        end
        if (ga || gm) begin
            exp_rd = e.rd;
            exp_wd = e.data;
            exp_we = (e.rd != 5'd0);
        end
        if (pa) aq.push_back(ea);
        if (pm) mq.push_back(em);
        last_pa = pa;
        last_pm = pm;
        if (reg_write === 1'b1) begin
            e.rd = rd; e.data = write_data;
            dlog.push_back(e);
        end
        if (model_chk) begin
            chk("model_reg_write", reg_write, exp_we);
            chk("model_rd", rd, exp_rd);
            chk("model_write_data", write_data, exp_wd);
            chk("model_alu_ready", alu_ready, (aq.size() < DEPTH));
            chk("model_mem_ready", mem_ready, (mq.size() < DEPTH));
        end
    endtask

    task automatic do_reset(input string tag);
        idle_inputs();
        rst_n = 1'b0;
        #2;
        chk({tag, "_rst_rd"}, rd, 0);
        chk({tag, "_rst_wd"}, write_data, 0);
        chk({tag, "_rst_we"}, reg_write, 0);
        chk({tag, "_rst_alu_ready"}, alu_ready, 0);
        chk({tag, "_rst_mem_ready"}, mem_ready, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        chk({tag, "_rel_alu_ready"}, alu_ready, 1);
        chk({tag, "_rel_mem_ready"}, mem_ready, 1);
    endtask

    vec_t vecs[16];
    int   a_idx, m_idx;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(1, 1, 32'h11,       1, 2, 32'h22, 0, 0, 32'h0,        1, 1);
        vecs[1]  = mk(0, 0, 32'h0,        0, 0, 32'h0,  1, 1, 32'h11,       1, 1);
        vecs[2]  = mk(0, 0, 32'h0,        0, 0, 32'h0,  1, 2, 32'h22,       1, 1);
        vecs[3]  = mk(0, 0, 32'h0,        0, 0, 32'h0,  0, 2, 32'h22,       1, 1);
        vecs[4]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 32'h0,  0, 2, 32'h22,       1, 1);
        vecs[5]  = mk(0, 0, 32'h0,        0, 0, 32'h0,  1, 5, 32'hDEADBEEF, 1, 1);
        vecs[6]  = mk(0, 0, 32'h0,        0, 0, 32'h0,  0, 5, 32'hDEADBEEF, 1, 1);
        vecs[7]  = mk(1, 0, 32'h5,        0, 0, 32'h0,  0, 5, 32'hDEADBEEF, 1, 1);
        vecs[8]  = mk(0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 32'h5,        1, 1);
        vecs[9]  = mk(0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 32'h5,        1, 1);
        vecs[10] = mk(1, 0, 32'h6,        1, 3, 32'h33, 0, 0, 32'h5,        1, 1);
        vecs[11] = mk(1, 0, 32'h7,        0, 0, 32'h0,  1, 3, 32'h33,       0, 1);
        vecs[12] = mk(1, 0, 32'h8,        0, 0, 32'h0,  0, 0, 32'h6,        1, 1);
        vecs[13] = mk(1, 0, 32'h8,        0, 0, 32'h0,  0, 0, 32'h7,        1, 1);
        vecs[14] = mk(0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 32'h8,        1, 1);
        vecs[15] = mk(0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 32'h8,        1, 1);

        model_chk = 1'b0;
        idle_inputs();
        model_reset();
        rst_n = 1'b0;
        #1;
        do_reset("init");

        for (int i = 0; i < 16; i++) begin
            alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_data = vecs[i].ad;
            mem_valid = vecs[i].mv; mem_rd = vecs[i].mrd; mem_data = vecs[i].md;
            tick();
            chk($sformatf("vec%0d_reg_write", i), reg_write, vecs[i].we);
            chk($sformatf("vec%0d_rd", i), rd, vecs[i].rd);
            chk($sformatf("vec%0d_write_data", i), write_data, vecs[i].wd);
            chk($sformatf("vec%0d_alu_ready", i), alu_ready, vecs[i].ar);
            chk($sformatf("vec%0d_mem_ready", i), mem_ready, vecs[i].mr);
        end

        // Sustained traffic from both sources: back-pressure on MEM and strict alternation.
        do_reset("rr");
        model_chk = 1'b1;
        dlog.delete();
        a_idx = 0;
        m_idx = 0;
        alu_valid = 1'b1; alu_rd = 5'd8;  alu_data = 32'hA000_0000;
        mem_valid = 1'b1; mem_rd = 5'd16; mem_data = 32'hB000_0000;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (c == 1) chk("bp_mem_ready_after_2_accepts", mem_ready, 0);
            if (last_pa) a_idx++;
            if (last_pm) m_idx++;
            alu_data = 32'hA000_0000 + 32'(a_idx);
            mem_data = 32'hB000_0000 + 32'(m_idx);
        end
        idle_inputs();
        for (int c = 0; c < 6; c++) tick();
        chk("rr_write_count", dlog.size(), a_idx + m_idx);
        for (int i = 0; i < dlog.size(); i++) begin
            chk($sformatf("rr_data%0d", i), dlog[i].data,
                ((i % 2) == 0) ? (32'hA000_0000 + 32'(i / 2)) : (32'hB000_0000 + 32'(i / 2)));
            chk($sformatf("rr_rd%0d", i), dlog[i].rd, ((i % 2) == 0) ? 5'd8 : 5'd16);
        end

        // Reset asserted while entries are queued.
        alu_valid = 1'b1; alu_rd = 5'd9;  alu_data = 32'hC0;
        mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 32'hD0;
        for (int c = 0; c < 3; c++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_rd", rd, 0);
        chk("midrst_wd", write_data, 0);
        chk("midrst_we", reg_write, 0);
        chk("midrst_alu_ready", alu_ready, 0);
        chk("midrst_mem_ready", mem_ready, 0);
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("postrst_no_write_c%0d", c), reg_write, 0);
        end

        // Randomized traffic; a source holds its payload until accepted.
        for (int c = 0; c < 400; c++) begin
            if (!(alu_valid && !last_pa)) begin
                alu_valid = ($urandom_range(0, 99) < 60);
                alu_rd    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
                alu_data  = $urandom;
            end
            if (!(mem_valid && !last_pm)) begin
                mem_valid = ($urandom_range(0, 99) < 60);
                mem_rd    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
                mem_data  = $urandom;
            end
            tick();
        end
        idle_inputs();
        for (int c = 0; c < 6; c++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register write-data width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, entries per source queue (power of two, at least 2).
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port alu_valid, input, 1, ALU result offered.
REQ-006 SHALL have port alu_rd, input, 5, ALU destination register.
REQ-007 SHALL have port alu_data, input, DATA_W, ALU result value.
REQ-008 SHALL have port alu_ready, output, 1, ALU queue can accept.
REQ-009 SHALL have port mem_valid, input, 1, load result offered.
REQ-010 SHALL have port mem_rd, input, 5, load destination register.
REQ-011 SHALL have port mem_data, input, DATA_W, load result value.
REQ-012 SHALL have port mem_ready, output, 1, load queue can accept.
REQ-013 SHALL have port rd, output, 5, register-file write address.
REQ-014 SHALL have port write_data, output, DATA_W, register-file write data.
REQ-015 SHALL have port reg_write, output, 1, register-file write enable.

Function
REQ-016 SHALL accept a source entry on a rising edge where that source's valid and ready are both high, pushing {rd, data} into that source's FIFO.
REQ-017 SHALL drive alu_ready/mem_ready high iff the matching FIFO count < FIFO_DEPTH; a pop in the same cycle does not raise ready (no pass-through).
REQ-018 SHALL treat valid without ready as no transfer; the source holds its payload.
REQ-019 SHALL pop at most one entry per cycle across both FIFOs and register it onto rd/write_data/reg_write at that edge.
REQ-020 SHALL give latency of exactly one cycle: an entry pushed into an empty FIFO at edge N, with no competing entry, appears with reg_write=1 after edge N+1.
REQ-021 SHALL, when only one FIFO is non-empty, pop from that FIFO.
REQ-022 SHALL, when both FIFOs are non-empty, grant the source not granted last (round-robin); the last-grant flag updates only on a pop.
REQ-023 SHALL set reg_write=0 in any cycle with no pop; rd and write_data then hold their previous values.
REQ-024 SHALL pop entries whose rd==0 normally but output reg_write=0 for them; rd and write_data SHALL still update.
REQ-025 SHALL preserve FIFO order within each source; no ordering is guaranteed between sources (same-rd hazards are resolved upstream).
REQ-026 SHALL allow a push and a pop on the same FIFO in one edge when count is between 1 and FIFO_DEPTH-1; count is unchanged.
REQ-027 SHALL use wrap-around read/write pointers of log2(FIFO_DEPTH) bits plus a count of log2(FIFO_DEPTH)+1 bits.

Reset
REQ-028 SHALL asynchronously clear, while rst_n=0: both FIFO counts and pointers to 0, rd=0, write_data=0, reg_write=0, last-grant=MEM (so ALU wins the first tie).
REQ-029 SHALL hold alu_ready=mem_ready=0 while rst_n=0 and raise them in the first cycle after release.
REQ-030 SHALL discard all queued entries on a reset asserted mid-operation; no reg_write pulse is emitted after release for pre-reset entries.

Structure
REQ-031 SHALL place the source-index constants (SRC_ALU=0, SRC_MEM=1) and the {rd, data} entry typedef in the shared core package.
REQ-032 SHALL instantiate a sub-module wb_fifo twice (one per source), parameterised by DATA_W and FIFO_DEPTH, exposing push, pop, full, empty, head.
REQ-033 SHALL keep arbitration and the output register in wb_arbiter itself.

Verification
REQ-034 SHALL cover single ALU write: alu rd=5, data=0xDEADBEEF at edge 1 -> after edge 2: reg_write=1, rd=5, write_data=0xDEADBEEF; reg_write=0 after edge 3.
REQ-035 SHALL cover tie after reset: alu(rd=1,0x11) and mem(rd=2,0x22) pushed at the same edge -> rd=1 written first, then rd=2 the next cycle.
REQ-036 SHALL cover back-pressure: hold mem_valid with arbiter blocked by continuous ALU traffic -> mem_ready=0 after 2 accepts, with no loss or duplication once drained.
REQ-037 SHALL cover x0 drop: alu rd=0, data=0x5 -> popped, reg_write stays 0, alu_ready re-asserts.
REQ-038 SHALL cover mid-operation reset: both FIFOs full, rst_n pulsed low -> all outputs 0 immediately; no reg_write pulse for 3 cycles after release.
REQ-039 SHALL cover sustained round-robin: both sources valid for 8 cycles -> grants strictly alternate ALU, MEM, ALU, and so on, with per-source order preserved.
